// File: rtl/ped_walk_scheduler_pkg.sv
// Shared types for the pedestrian walk scheduler: FSM states and crosswalk indices.
package ped_walk_scheduler_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0001,
        ST_REQ      = 4'b0010,
        ST_WALK     = 4'b0100,
        ST_COOLDOWN = 4'b1000
    } state_e;

    localparam int unsigned XW_A = 0;
    localparam int unsigned XW_B = 1;

endpackage

// File: rtl/ped_btn_debounce.sv
// Per-crosswalk press debouncer: one pend event per held press, re-armed by a low sample.
module ped_btn_debounce #(
    parameter int unsigned DEB_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic clr,
    input  logic block,
    output logic pend
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic          armed_q;
    logic          pend_q;
    logic          hit;

    assign hit  = btn && armed_q && (cnt_q == CW'(DEB_CYCLES - 1));
    assign pend = pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
            pend_q  <= 1'b0;
        end else begin
            if (!btn) begin
                cnt_q   <= '0;
                armed_q <= 1'b1;
            end else begin
                if (cnt_q != CW'(DEB_CYCLES))
                    cnt_q <= cnt_q + 1'b1;
                if (hit)
                    armed_q <= 1'b0;
            end
            // A grant for this crosswalk wins over a press landing on the same edge.
            if (clr)
                pend_q <= 1'b0;
            else if (hit && !block)
                pend_q <= 1'b1;
        end
    end

endmodule

// File: rtl/ped_walk_scheduler.sv
// Pedestrian request scheduler: raises one request, grants one crosswalk per walk phase.
module ped_walk_scheduler
    import ped_walk_scheduler_pkg::*;
#(
    parameter  int unsigned DEB_CYCLES = 3,
    parameter  int unsigned COOLDOWN   = 8,
    parameter  int unsigned MAX_WAIT   = 31,
    localparam int unsigned WW         = $clog2(MAX_WAIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_a,
    input  logic          btn_b,
    input  logic          walk_active,
    output logic          ped_req,
    output logic          serve_a,
    output logic          serve_b,
    output logic          pend_a,
    output logic          pend_b,
    output logic [WW-1:0] wait_cnt,
    output logic          urgent
);

    localparam int unsigned CCW = $clog2(COOLDOWN + 1);

    state_e          state_q;
    logic            ped_req_q, serve_a_q, serve_b_q, urgent_q;
    logic            last_q;
    logic [WW-1:0]   wait_q, wait_d;
    logic [CCW-1:0]  cool_q;
    logic            pick_b, grant, grant_a, grant_b;

    ped_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk(clk), .rst(rst), .btn(btn_a), .clr(grant_a), .block(serve_a_q), .pend(pend_a)
    );

    ped_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk(clk), .rst(rst), .btn(btn_b), .clr(grant_b), .block(serve_b_q), .pend(pend_b)
    );

    // Round-robin: on a tie, serve whichever crosswalk was not served last.
    assign pick_b  = pend_b && (!pend_a || (last_q == 1'(XW_A)));
    assign grant   = (state_q == ST_REQ) && walk_active && (pend_a || pend_b);
    assign grant_a = grant && !pick_b;
    assign grant_b = grant && pick_b;
    assign wait_d  = (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ped_req_q <= 1'b0;
            serve_a_q <= 1'b0;
            serve_b_q <= 1'b0;
            wait_q    <= '0;
            urgent_q  <= 1'b0;
            last_q    <= 1'(XW_B);
            cool_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ped_req_q <= 1'b0;
                    if (pend_a || pend_b) begin
                        state_q   <= ST_REQ;
                        ped_req_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (grant) begin
                        state_q   <= ST_WALK;
                        ped_req_q <= 1'b0;
                        serve_a_q <= grant_a;
                        serve_b_q <= grant_b;
                        last_q    <= pick_b;
                        wait_q    <= '0;
                        urgent_q  <= 1'b0;
                    end else begin
                        wait_q   <= wait_d;
                        urgent_q <= (wait_d == WW'(MAX_WAIT));
                    end
                end
                ST_WALK: begin
                    if (!walk_active) begin
                        state_q   <= ST_COOLDOWN;
                        serve_a_q <= 1'b0;
                        serve_b_q <= 1'b0;
                        cool_q    <= '0;
                    end
                end
                ST_COOLDOWN: begin
                    if (cool_q == CCW'(COOLDOWN - 1)) begin
                        state_q   <= (pend_a || pend_b) ? ST_REQ : ST_IDLE;
                        ped_req_q <= pend_a || pend_b;
                    end else begin
                        cool_q <= cool_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    ped_req_q <= 1'b0;
                    serve_a_q <= 1'b0;
                    serve_b_q <= 1'b0;
                    wait_q    <= '0;
                    urgent_q  <= 1'b0;
                    cool_q    <= '0;
                end
            endcase
        end
    end

    assign ped_req  = ped_req_q;
    assign serve_a  = serve_a_q;
    assign serve_b  = serve_b_q;
    assign wait_cnt = wait_q;
    assign urgent   = urgent_q;

endmodule

// File: tb/tb_ped_walk_scheduler.sv
// Directed scenarios plus randomized traffic, checked every cycle against a timestamp-based model.
module tb_ped_walk_scheduler;

    localparam int DEB  = 3;
    localparam int COOL = 8;
    localparam int MAXW = 31;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_WALK = 2;
    localparam int P_COOL = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_a = 1'b0, btn_b = 1'b0, walk_active = 1'b0;
    logic       ped_req, serve_a, serve_b, pend_a, pend_b, urgent;
    logic [4:0] wait_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: run lengths and event timestamps rather than counters.
    int t = 0;
    int run_a, run_b;
    bit m_pa, m_pb, m_req, m_urg;
    int ph, req_start, cool_start, m_srv, m_last, m_wait;

    ped_walk_scheduler #(.DEB_CYCLES(DEB), .COOLDOWN(COOL), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .btn_a(btn_a), .btn_b(btn_b), .walk_active(walk_active),
        .ped_req(ped_req), .serve_a(serve_a), .serve_b(serve_b),
        .pend_a(pend_a), .pend_b(pend_b), .wait_cnt(wait_cnt), .urgent(urgent)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        run_a = 0; run_b = 0;
        m_pa = 0; m_pb = 0; m_req = 0; m_urg = 0;
        ph = P_IDLE; req_start = 0; cool_start = 0;
        m_srv = 0; m_last = 2; m_wait = 0;
    endtask

    task automatic model_step(input bit ba, input bit bb, input bit wk);
        bit ev_a, ev_b, any_old, npa, npb;
        int g;
        t++;
        ev_a  = ba && (run_a + 1 == DEB);
        ev_b  = bb && (run_b + 1 == DEB);
        run_a = ba ? run_a + 1 : 0;
        run_b = bb ? run_b + 1 : 0;
        any_old = m_pa || m_pb;
        g = 0;
        if (ph == P_REQ && wk && any_old)
            g = (m_pa && m_pb) ? ((m_last == 2) ? 1 : 2) : (m_pa ? 1 : 2);
        npa = (g == 1) ? 1'b0 : ((ev_a && m_srv != 1) ? 1'b1 : m_pa);
        npb = (g == 2) ? 1'b0 : ((ev_b && m_srv != 2) ? 1'b1 : m_pb);
        case (ph)
            P_IDLE: if (any_old) begin ph = P_REQ; req_start = t; m_req = 1; end
            P_REQ: begin
                if (g != 0) begin
                    ph = P_WALK; m_srv = g; m_last = g; m_req = 0; m_wait = 0; m_urg = 0;
                end else begin
                    m_wait = (t - req_start > MAXW) ? MAXW : t - req_start;
                    m_urg  = (m_wait == MAXW);
                end
            end
            P_WALK: if (!wk) begin ph = P_COOL; m_srv = 0; cool_start = t; end
            default: if (t - cool_start == COOL) begin
                ph = any_old ? P_REQ : P_IDLE;
                m_req = any_old;
                req_start = t;
            end
        endcase
        m_pa = npa; m_pb = npb;
    endtask

    task automatic compare_all();
        check_val("ped_req", ped_req, m_req);
        check_val("serve_a", serve_a, m_srv == 1);
        check_val("serve_b", serve_b, m_srv == 2);
        check_val("pend_a", pend_a, m_pa);
        check_val("pend_b", pend_b, m_pb);
        check_val("wait_cnt", wait_cnt, m_wait);
        check_val("urgent", urgent, m_urg);
        check_val("excl", (serve_a & serve_b) | (ped_req & (serve_a | serve_b)), 0);
    endtask

    // Called at a falling edge: drive inputs, advance model, compare at next falling edge.
    task automatic apply_cycle(input bit ba, input bit bb, input bit wk);
        btn_a = ba; btn_b = bb; walk_active = wk;
        model_step(ba, bb, wk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check_val("rst_ped_req", ped_req, 0);
        check_val("rst_serve", {serve_a, serve_b}, 0);
        check_val("rst_pend", {pend_a, pend_b}, 0);
        check_val("rst_wait", wait_cnt, 0);
        check_val("rst_urgent", urgent, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input bit wk);
        for (int i = 0; i < n; i++) apply_cycle(0, 0, wk);
    endtask

    initial begin
        int k;
        bit ba, bb, wk;
        model_reset();
        @(negedge clk);
        do_reset();

        // 1: clean press on A, walk 5 cycles after ped_req
        for (int i = 0; i < 3; i++) apply_cycle(1, 0, 0);
        check_val("t1_pend_a", pend_a, 1);
        apply_cycle(0, 0, 0);
        check_val("t1_ped_req", ped_req, 1);
        idle_cycles(5, 0);
        check_val("t1_wait", wait_cnt, 5);
        apply_cycle(0, 0, 1);
        check_val("t1_serve_a", serve_a, 1);
        check_val("t1_pend_a0", pend_a, 0);
        idle_cycles(3, 1);
        idle_cycles(COOL + 2, 0);

        // 2: two short bounces never latch
        apply_cycle(1, 0, 0); apply_cycle(1, 0, 0); apply_cycle(0, 0, 0);
        apply_cycle(1, 0, 0); apply_cycle(1, 0, 0); apply_cycle(0, 0, 0);
        idle_cycles(2, 0);
        check_val("t2_pend_a", pend_a, 0);
        check_val("t2_ped_req", ped_req, 0);

        // 3: simultaneous presses, A first then B after exactly COOL cycles
        do_reset();
        for (int i = 0; i < 3; i++) apply_cycle(1, 1, 0);
        check_val("t3_both", {pend_a, pend_b}, 2'b11);
        idle_cycles(3, 0);
        apply_cycle(0, 0, 1);
        check_val("t3_first_a", serve_a, 1);
        idle_cycles(3, 1);
        apply_cycle(0, 0, 0);
        k = 0;
        while (ped_req !== 1'b1 && k < 20) begin
            apply_cycle(0, 0, 0);
            k++;
        end
        check_val("t3_cool_len", k, COOL);
        apply_cycle(0, 0, 1);
        check_val("t3_second_b", serve_b, 1);
        idle_cycles(2, 1);
        idle_cycles(COOL + 2, 0);

        // 4: wait counter saturation and urgent
        for (int i = 0; i < 3; i++) apply_cycle(0, 1, 0);
        idle_cycles(40, 0);
        check_val("t4_wait_sat", wait_cnt, MAXW);
        check_val("t4_urgent", urgent, 1);
        apply_cycle(0, 0, 1);
        check_val("t4_serve_b", serve_b, 1);
        check_val("t4_wait0", wait_cnt, 0);
        check_val("t4_urgent0", urgent, 0);
        apply_cycle(0, 0, 0);
        idle_cycles(COOL + 2, 0);

        // 5: press on served A dropped, B pressed in cooldown is served next
        for (int i = 0; i < 3; i++) apply_cycle(1, 0, 0);
        apply_cycle(0, 0, 0);
        apply_cycle(0, 0, 1);
        check_val("t5_serve_a", serve_a, 1);
        for (int i = 0; i < 3; i++) apply_cycle(1, 0, 1);
        apply_cycle(0, 0, 1);
        check_val("t5_drop_a", pend_a, 0);
        apply_cycle(0, 0, 0);
        for (int i = 0; i < 3; i++) apply_cycle(0, 1, 0);
        check_val("t5_pend_b", pend_b, 1);
        idle_cycles(COOL, 0);
        apply_cycle(0, 0, 1);
        check_val("t5_only_b", {serve_a, serve_b}, 2'b01);
        idle_cycles(2, 1);

        // 6: async reset mid-walk, then A wins the first tie
        check_val("t6_pre_b", serve_b, 1);
        do_reset();
        for (int i = 0; i < 3; i++) apply_cycle(1, 1, 0);
        apply_cycle(0, 0, 0);
        apply_cycle(0, 0, 1);
        check_val("t6_first_a", serve_a, 1);
        idle_cycles(2, 1);
        idle_cycles(COOL + 2, 0);

        // Randomized traffic
        ba = 0; bb = 0; wk = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) ba = ~ba;
            if ($urandom_range(0, 3) == 0) bb = ~bb;
            if ($urandom_range(0, 9) == 0) wk = ~wk;
            apply_cycle(ba, bb, wk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
